// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage MIPS pipeline: tracks EX/MEM/WB
// destination shadows, stalls on load-use (or RAW without forwarding), flushes on branch/jump.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_AW = 5,
  parameter bit          FWD_EN = 1'b1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_uses_rs_i,
  input  logic              id_uses_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              id_branch_i,
  input  logic              id_jump_i,
  input  logic              ex_branch_taken_i,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              ifid_flush_o,
  output logic              idex_bubble_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
    logic              branch;
  } shadow_t;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  function automatic logic hit(input shadow_t s, input logic [REG_AW-1:0] r);
    return s.valid && s.regwrite && (s.rd != '0) && (s.rd == r);
  endfunction

  // The younger producer (MEM) holds the newer value, so it outranks WB.
  function automatic logic [1:0] fwd_sel(input shadow_t mem, input shadow_t wb,
                                         input logic [REG_AW-1:0] r);
    if (hit(mem, r)) return FWD_EXMEM;
    if (hit(wb, r))  return FWD_MEMWB;
    return FWD_REG;
  endfunction

  logic       running_q;
  logic       id_valid_q;
  shadow_t    ex_q, mem_q, wb_q;
  shadow_t    next_ex;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic ex_hit, mem_hit, hazard;
  logic branch_taken, stall_req, stall, jump;
  logic unused_wb;

  assign ex_hit  = (id_uses_rs_i && hit(ex_q, id_rs_i))  || (id_uses_rt_i && hit(ex_q, id_rt_i));
  assign mem_hit = (id_uses_rs_i && hit(mem_q, id_rs_i)) || (id_uses_rt_i && hit(mem_q, id_rt_i));
  assign hazard  = FWD_EN ? (ex_hit && ex_q.memread) : (ex_hit || mem_hit);

  // Taken branch squashes everything younger, so it masks both stall and jump.
  assign branch_taken = running_q && ex_q.valid && ex_q.branch && ex_branch_taken_i;
  assign stall_req    = running_q && id_valid_q && hazard;
  assign stall        = stall_req && !branch_taken;
  assign jump         = running_q && id_valid_q && id_jump_i && !branch_taken && !stall_req;

  assign pc_write_o    = running_q && !stall;
  assign ifid_write_o  = running_q && !stall && !branch_taken && !jump;
  assign ifid_flush_o  = branch_taken || jump;
  assign idex_bubble_o = branch_taken || stall;

  assign fwd_a_o = FWD_EN ? fwd_sel(mem_q, wb_q, ex_q.rs) : FWD_REG;
  assign fwd_b_o = FWD_EN ? fwd_sel(mem_q, wb_q, ex_q.rt) : FWD_REG;

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

  assign next_ex = '{valid:    id_valid_q && !idex_bubble_o,
                     rs:       id_rs_i,
                     rt:       id_rt_i,
                     rd:       id_rd_i,
                     regwrite: id_regwrite_i,
                     memread:  id_memread_i,
                     branch:   id_branch_i};

  // WB is only a forwarding source; most of its fields are carried for completeness.
  assign unused_wb = ^wb_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      // NOTE: the shadows are a handful of flops, not a RAM, so they reset with the rest of the state.
      running_q   <= 1'b0;
      id_valid_q  <= 1'b0;
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      running_q <= running_q || start_i;
      if (running_q) begin
        // NOTE: non-blocking so MEM and WB capture the pre-edge EX and MEM contents.
        ex_q  <= next_ex;
        mem_q <= ex_q;
        wb_q  <= mem_q;
        if (ifid_flush_o)
          id_valid_q <= 1'b0;
        else if (!stall)
          id_valid_q <= 1'b1;
        if (stall && (stall_cnt_q != '1))
          stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        if (ifid_flush_o && (flush_cnt_q != '1))
          flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized bench for pipeline_hazard_ctrl: a forwarding instance and a non-forwarding instance
// with narrow counters run side by side against a queue-of-stages reference model.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       start;
  logic [4:0] rs, rt, rd;
  logic       uses_rs, uses_rt, regwrite, memread, branch, jump, taken;

  // index 0: FWD_EN=0, CNT_W=3   index 1: FWD_EN=1, CNT_W=16
  logic       pc_w [2];
  logic       ifw  [2];
  logic       flsh [2];
  logic       bub  [2];
  logic [1:0] fa   [2];
  logic [1:0] fb   [2];
  logic [2:0]  scnt_n, fcnt_n;
  logic [15:0] scnt_f, fcnt_f;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_AW(5), .FWD_EN(1'b0), .CNT_W(3)) u_dut_nofwd (
    .clk_i(clk), .rst_i(rst_n), .start_i(start),
    .id_rs_i(rs), .id_rt_i(rt), .id_uses_rs_i(uses_rs), .id_uses_rt_i(uses_rt),
    .id_rd_i(rd), .id_regwrite_i(regwrite), .id_memread_i(memread),
    .id_branch_i(branch), .id_jump_i(jump), .ex_branch_taken_i(taken),
    .pc_write_o(pc_w[0]), .ifid_write_o(ifw[0]), .ifid_flush_o(flsh[0]),
    .idex_bubble_o(bub[0]), .fwd_a_o(fa[0]), .fwd_b_o(fb[0]),
    .stall_cnt_o(scnt_n), .flush_cnt_o(fcnt_n)
  );

  pipeline_hazard_ctrl #(.REG_AW(5), .FWD_EN(1'b1), .CNT_W(16)) u_dut_fwd (
    .clk_i(clk), .rst_i(rst_n), .start_i(start),
    .id_rs_i(rs), .id_rt_i(rt), .id_uses_rs_i(uses_rs), .id_uses_rt_i(uses_rt),
    .id_rd_i(rd), .id_regwrite_i(regwrite), .id_memread_i(memread),
    .id_branch_i(branch), .id_jump_i(jump), .ex_branch_taken_i(taken),
    .pc_write_o(pc_w[1]), .ifid_write_o(ifw[1]), .ifid_flush_o(flsh[1]),
    .idex_bubble_o(bub[1]), .fwd_a_o(fa[1]), .fwd_b_o(fb[1]),
    .stall_cnt_o(scnt_f), .flush_cnt_o(fcnt_f)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    bit       valid;
    bit [4:0] rs, rt, rd;
    bit       regwrite, memread, branch;
  } stage_t;

  typedef enum bit [2:0] {ACT_IDLE, ACT_BRANCH, ACT_STALL, ACT_JUMP, ACT_NORMAL} act_t;

  typedef struct packed {
    act_t     act;
    bit       pc, ifw, flush, bubble;
    bit [1:0] fa, fb;
  } exp_t;

  stage_t pipe [2][3];   // [config][0=EX,1=MEM,2=WB]
  bit     m_run;
  bit     m_idv   [2];
  int     m_stall [2];
  int     m_flush [2];
  exp_t   pred    [2];

  function automatic int cap(int c);
    return (c == 1) ? 65535 : 7;
  endfunction

  function automatic bit mhit(stage_t s, bit [4:0] r);
    return s.valid && s.regwrite && (s.rd != 5'd0) && (s.rd == r);
  endfunction

  function automatic bit id_reads_from(stage_t s);
    return (uses_rs && mhit(s, rs)) || (uses_rt && mhit(s, rt));
  endfunction

  function automatic bit [1:0] fsel(int c, bit [4:0] r);
    if (c == 0)            return 2'b00;
    if (mhit(pipe[c][1], r)) return 2'b10;
    if (mhit(pipe[c][2], r)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t predict(int c);
    exp_t e;
    bit   haz = 1'b0;
    if (c == 1) haz = pipe[c][0].memread && id_reads_from(pipe[c][0]);
    else for (int s = 0; s < 2; s++) haz |= id_reads_from(pipe[c][s]);

    e = '0;
    if (!m_run)                                                   e.act = ACT_IDLE;
    else if (pipe[c][0].valid && pipe[c][0].branch && taken)     e.act = ACT_BRANCH;
    else if (m_idv[c] && haz)                                     e.act = ACT_STALL;
    else if (m_idv[c] && jump)                                    e.act = ACT_JUMP;
    else                                                          e.act = ACT_NORMAL;

    case (e.act)
      ACT_BRANCH: begin e.pc = 1; e.flush = 1; e.bubble = 1; end
      ACT_STALL:  begin e.bubble = 1; end
      ACT_JUMP:   begin e.pc = 1; e.flush = 1; end
      ACT_NORMAL: begin e.pc = 1; e.ifw = 1; end
      default:    ;
    endcase
    e.fa = fsel(c, pipe[c][0].rs);
    e.fb = fsel(c, pipe[c][0].rt);
    return e;
  endfunction

  task automatic model_reset();
    m_run = 1'b0;
    for (int c = 0; c < 2; c++) begin
      m_idv[c] = 1'b0; m_stall[c] = 0; m_flush[c] = 0;
      for (int s = 0; s < 3; s++) pipe[c][s] = '0;
    end
  endtask

  task automatic model_update();
    if (m_run) begin
      for (int c = 0; c < 2; c++) begin
        stage_t nx;
        nx = '{valid: m_idv[c] && !pred[c].bubble, rs: rs, rt: rt, rd: rd,
               regwrite: regwrite, memread: memread, branch: branch};
        pipe[c][2] = pipe[c][1];
        pipe[c][1] = pipe[c][0];
        pipe[c][0] = nx;
        if (pred[c].flush) m_idv[c] = 1'b0;
        else if (pred[c].act != ACT_STALL) m_idv[c] = 1'b1;
        if (pred[c].act == ACT_STALL && m_stall[c] < cap(c)) m_stall[c]++;
        if (pred[c].flush && m_flush[c] < cap(c)) m_flush[c]++;
      end
    end
    m_run = m_run || start;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic string tag(string n, int c);
    return $sformatf("%s[%s]", n, (c == 1) ? "fwd" : "nofwd");
  endfunction

  task automatic eval();
    #1;
    for (int c = 0; c < 2; c++) begin
      pred[c] = predict(c);
      check(tag("pc_write", c),    32'(pc_w[c]), 32'(pred[c].pc));
      check(tag("ifid_write", c),  32'(ifw[c]),  32'(pred[c].ifw));
      check(tag("ifid_flush", c),  32'(flsh[c]), 32'(pred[c].flush));
      check(tag("idex_bubble", c), 32'(bub[c]),  32'(pred[c].bubble));
      check(tag("fwd_a", c),       32'(fa[c]),   32'(pred[c].fa));
      check(tag("fwd_b", c),       32'(fb[c]),   32'(pred[c].fb));
    end
    check(tag("stall_cnt", 0), 32'(scnt_n), m_stall[0]);
    check(tag("flush_cnt", 0), 32'(fcnt_n), m_flush[0]);
    check(tag("stall_cnt", 1), 32'(scnt_f), m_stall[1]);
    check(tag("flush_cnt", 1), 32'(fcnt_f), m_flush[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_update();
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  task automatic drive(input logic [4:0] a, input logic [4:0] b, input logic ua, input logic ub,
                       input logic [4:0] d, input logic rw, input logic mr);
    rs = a; rt = b; uses_rs = ua; uses_rt = ub; rd = d; regwrite = rw; memread = mr;
    branch = 1'b0; jump = 1'b0; taken = 1'b0;
  endtask

  task automatic drive_random();
    start    = ($urandom_range(0, 7) == 0);
    rs       = 5'($urandom_range(0, 3));
    rt       = 5'($urandom_range(0, 3));
    rd       = 5'($urandom_range(0, 3));
    uses_rs  = 1'($urandom_range(0, 1));
    uses_rt  = 1'($urandom_range(0, 1));
    regwrite = ($urandom_range(0, 3) != 0);
    memread  = ($urandom_range(0, 2) == 0);
    branch   = ($urandom_range(0, 3) == 0);
    jump     = ($urandom_range(0, 7) == 0);
    taken    = 1'($urandom_range(0, 1));
  endtask

  initial begin
    start = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    model_reset();

    @(negedge clk);
    eval();                       // reset state
    tick();
    rst_n = 1'b1;

    start = 1'b1;
    eval();                       // start sampled this cycle, not yet running
    tick();
    start = 1'b0;
    eval();
    check("start_sticky_pc_write", 32'(pc_w[1]), 32'd1);
    tick();
    eval();                       // idle instruction in ID
    tick();

    // lw $2 followed by add $3,$2,$4
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd2, 1'b1, 1'b1);
    eval();
    tick();
    drive(5'd2, 5'd4, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    eval();
    check("loaduse_bubble", 32'(bub[1]), 32'd1);
    check("loaduse_pc_hold", 32'(pc_w[1]), 32'd0);
    tick();
    eval();
    check("loaduse_release", 32'(pc_w[1]), 32'd1);
    tick();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    eval();
    check("wb_forward_a", 32'(fa[1]), 32'b01);
    check("loaduse_stall_cnt", 32'(scnt_f), 32'd1);
    tick();

    repeat (3000) begin
      drive_random();
      eval();
      tick();
    end

    // asynchronous reset in the middle of a cycle
    drive_random();
    eval();
    #1 rst_n = 1'b0;
    #1;
    for (int c = 0; c < 2; c++) begin
      check(tag("rst_pc_write", c),    32'(pc_w[c]), 32'd0);
      check(tag("rst_ifid_write", c),  32'(ifw[c]),  32'd0);
      check(tag("rst_ifid_flush", c),  32'(flsh[c]), 32'd0);
      check(tag("rst_idex_bubble", c), 32'(bub[c]),  32'd0);
      check(tag("rst_fwd_a", c),       32'(fa[c]),   32'd0);
      check(tag("rst_fwd_b", c),       32'(fb[c]),   32'd0);
    end
    check("rst_stall_cnt_nofwd", 32'(scnt_n), 32'd0);
    check("rst_flush_cnt_nofwd", 32'(fcnt_n), 32'd0);
    check("rst_stall_cnt_fwd",   32'(scnt_f), 32'd0);
    check("rst_flush_cnt_fwd",   32'(fcnt_f), 32'd0);
    model_reset();
    tick();
    rst_n = 1'b1;

    repeat (500) begin
      drive_random();
      eval();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
